spi_slave_shifter: RTL and testbench

//  SPI slave (responder) datapath: the far end of the SCLK that the master Baud_Rate_Generator produces.

---
 rtl/spi_slave_shifter_pkg.sv | 15 +
 rtl/spi_slave_shifter_if.sv | 35 +++
 rtl/spi_slave_shifter_edge_sync.sv | 26 ++
 rtl/spi_slave_shifter.sv | 150 +++++++++++++++
 tb/tb_spi_slave_shifter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_shifter_pkg.sv
// Shared types and defaults for the SPI slave shifter.
package spi_slave_shifter_pkg;

    localparam int DEFAULT_DATA_W      = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_slave_shifter_if.sv
// Pin side and parallel side of the SPI slave; slave modport is the shifter's view.
interface spi_slave_shifter_if
    import spi_slave_shifter_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              cpol;
    logic              cpha;
    logic              lsbfe;
    logic              ss_n;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ack;
    logic              overrun;
    logic              underrun;
    logic              busy;

    modport slave (
        input  cpol, cpha, lsbfe, ss_n, sclk, mosi, tx_data, tx_valid, rx_ack,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, underrun, busy
    );

    modport master (
        output cpol, cpha, lsbfe, ss_n, sclk, mosi, tx_data, tx_valid, rx_ack,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, underrun, busy
    );

endinterface

// File: rtl/spi_slave_shifter_edge_sync.sv
// Multi-flop synchroniser with one-cycle rise/fall pulses on the synchronised level.
module spi_slave_shifter_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic PClk,
    input  logic PRESET,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    // sr[STAGES-1] is the synchronised level, sr[STAGES] its previous value
    logic [STAGES:0] sr;

    always_ff @(posedge PClk or posedge PRESET) begin
        if (PRESET) sr <= {(STAGES+1){RST_VAL}};
        else        sr <= {sr[STAGES-1:0], d};
    end

    assign q    = sr[STAGES-1];
    assign rise =  sr[STAGES-1] & ~sr[STAGES];
    assign fall = ~sr[STAGES-1] &  sr[STAGES];

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave datapath: oversampled pins, TX holding/shift registers, RX shifter, flags.
module spi_slave_shifter
    import spi_slave_shifter_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input logic                PClk,
    input logic                PRESET,
    spi_slave_shifter_if.slave bus
);

    localparam int               CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic                sclk_s, sclk_rise, sclk_fall;
    logic                ss_s, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic                mosi_s;
    logic                sclk_edge, lead_e, trail_e, sample_e, shift_e;
    logic                in_shift, frame_end, frame_done, tx_accept;
    logic                hold_full, load_empty, underrun_q;
    logic [DATA_W-1:0]   hold_q, load_word, tx_sh, rx_sh, rx_data_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic                miso_q, rx_valid_q, overrun_q;

    function automatic logic [CNT_W-1:0] bit_idx(input logic [CNT_W-1:0] n, input logic lsb);
        return lsb ? n : LAST - n;
    endfunction

    spi_slave_shifter_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .PClk(PClk), .PRESET(PRESET), .d(bus.sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_slave_shifter_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .PClk(PClk), .PRESET(PRESET), .d(bus.ss_n), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge PClk or posedge PRESET) begin
        if (PRESET) mosi_sr <= '0;
        else        mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], bus.mosi};
    end
    assign mosi_s = mosi_sr[SYNC_STAGES-1];

    // Leading edge: synchronised sclk just moved away from cpol
    assign sclk_edge = sclk_rise | sclk_fall;
    assign lead_e    = sclk_edge &  (sclk_s ^ bus.cpol);
    assign trail_e   = sclk_edge & ~(sclk_s ^ bus.cpol);
    assign sample_e  = bus.cpha ? trail_e : lead_e;
    assign shift_e   = bus.cpha ? lead_e  : trail_e;

    assign in_shift  = (state_q == SHIFT);
    assign frame_end = in_shift & sample_e & (bit_cnt == LAST) & ~ss_rise;
    assign tx_accept = bus.tx_valid & ~hold_full;
    assign load_word = hold_full ? hold_q : '0;

    always_ff @(posedge PClk or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (frame_end) state_d = LOAD;
            default: state_d = IDLE;
        endcase
        if (ss_rise) state_d = IDLE;
    end

    always_ff @(posedge PClk or posedge PRESET) begin
        if (PRESET) begin
            hold_q     <= '0;
            hold_full  <= 1'b0;
            load_empty <= 1'b0;
            underrun_q <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (tx_accept) hold_q <= bus.tx_data;
            if (state_q == LOAD) begin
                hold_full  <= tx_accept;
                load_empty <= ~hold_full;
            end else if (tx_accept) begin
                hold_full  <= 1'b1;
            end
            // An empty load only counts as underrun once the master actually clocks that frame
            if (in_shift && sample_e && bit_cnt == '0 && load_empty && !ss_rise)
                underrun_q <= 1'b1;
            else if (tx_accept)
                underrun_q <= 1'b0;
        end
    end

    always_ff @(posedge PClk or posedge PRESET) begin
        if (PRESET) begin
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            miso_q  <= 1'b0;
        end else if (ss_rise) begin
            bit_cnt <= '0;
            miso_q  <= 1'b0;
        end else if (state_q == LOAD) begin
            tx_sh   <= load_word;
            bit_cnt <= '0;
            if (!bus.cpha) miso_q <= load_word[bit_idx('0, bus.lsbfe)];
        end else if (in_shift) begin
            if (sample_e) begin
                rx_sh   <= bus.lsbfe ? {mosi_s, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], mosi_s};
                bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
            end
            // cpha=0: bit0 went out in LOAD, so a shift edge before any sample is stale
            if (shift_e && (bus.cpha || bit_cnt != '0))
                miso_q <= tx_sh[bit_idx(bit_cnt, bus.lsbfe)];
        end
    end

    always_ff @(posedge PClk or posedge PRESET) begin
        if (PRESET) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (frame_done) begin
            if (!rx_valid_q || bus.rx_ack) begin
                rx_data_q  <= rx_sh;
                rx_valid_q <= 1'b1;
                if (rx_valid_q) overrun_q <= 1'b0;
            end else begin
                overrun_q  <= 1'b1;
            end
        end else if (bus.rx_ack && rx_valid_q) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end
    end

    assign bus.miso     = miso_q;
    assign bus.miso_oe  = ~ss_s;
    assign bus.tx_ready = ~hold_full;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.overrun  = overrun_q;
    assign bus.underrun = underrun_q;
    assign bus.busy     = in_shift;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Scoreboard bench: SPI master model drives frames, a monitor checks rx_data against a queue.
module tb_spi_slave_shifter;
    import spi_slave_shifter_pkg::*;

    localparam int W    = 8;
    localparam int HALF = 8;

    logic PClk = 1'b0;
    logic PRESET;
    always #5 PClk = ~PClk;

    spi_slave_shifter_if #(.DATA_W(W)) bus();

    spi_slave_shifter #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .PClk(PClk), .PRESET(PRESET), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_rx_q[$];
    logic mon_prev = 1'b0;

    // reference model of what the slave should hold
    logic         m_hold_full, m_rx_pend, m_ovr, m_unr;
    logic [W-1:0] m_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_hold_full = 0; m_rx_pend = 0; m_ovr = 0; m_unr = 0; m_hold = '0;
    endtask

    task automatic m_write(input logic [W-1:0] d);
        m_hold = d; m_hold_full = 1; m_unr = 0;
    endtask

    // a clocked frame consumes the holding byte; full frames deliver or overrun
    task automatic m_frame(input logic [W-1:0] mo, input bit full, output logic [W-1:0] exp_miso);
        exp_miso = m_hold_full ? m_hold : '0;
        if (!m_hold_full) m_unr = 1;
        m_hold_full = 0;
        if (full) begin
            if (!m_rx_pend) begin
                m_rx_pend = 1;
                exp_rx_q.push_back(mo);
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_rx_valid"}, bus.rx_valid, m_rx_pend);
        check({tag, "_overrun"},  bus.overrun,  m_ovr);
        check({tag, "_underrun"}, bus.underrun, m_unr);
        check({tag, "_tx_ready"}, bus.tx_ready, !m_hold_full);
    endtask

    task automatic half();
        repeat (HALF) @(negedge PClk);
    endtask

    task automatic tx_drive(input logic [W-1:0] d);
        int n = 0;
        while (!bus.tx_ready && n < 400) begin
            @(negedge PClk);
            n++;
        end
        if (!bus.tx_ready) begin
            checks++; errors++;
            $display("FAIL tx_ready_timeout: got 0 expected 1");
        end
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge PClk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic tx_write(input logic [W-1:0] d);
        tx_drive(d);
        m_write(d);
    endtask

    task automatic do_ack();
        bus.rx_ack = 1'b1;
        @(negedge PClk);
        bus.rx_ack = 1'b0;
        if (m_rx_pend) begin m_rx_pend = 0; m_ovr = 0; end
        @(negedge PClk);
    endtask

    task automatic set_mode(input logic [1:0] mode, input logic lsb);
        bus.cpol  = mode[1];
        bus.cpha  = mode[0];
        bus.lsbfe = lsb;
        bus.sclk  = mode[1];
        repeat (6) @(negedge PClk);
    endtask

    // master: nbits clock cycles; ss_n stays low if end_ss=0
    task automatic spi_xfer(input logic [W-1:0] dout, input int nbits, input bit end_ss,
                            output logic [W-1:0] din);
        din = '0;
        if (bus.ss_n) begin
            bus.ss_n = 1'b0;
            half();
        end
        for (int i = 0; i < nbits; i++) begin
            int k;
            k = bus.lsbfe ? i : W - 1 - i;
            if (!bus.cpha) begin
                bus.mosi = dout[k];
                half();
                bus.sclk = ~bus.cpol;
                din[k]   = bus.miso;
                half();
                bus.sclk = bus.cpol;
            end else begin
                half();
                bus.sclk = ~bus.cpol;
                bus.mosi = dout[k];
                half();
                bus.sclk = bus.cpol;
                din[k]   = bus.miso;
            end
        end
        if (end_ss) begin
            half();
            bus.ss_n = 1'b1;
            half();
            half();
        end
    endtask

    // monitor: every new rx_valid must match the next expected frame
    initial begin
        forever begin
            @(negedge PClk);
            if (bus.rx_valid && !mon_prev) begin
                if (exp_rx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_unexpected: got %0h expected no frame", bus.rx_data);
                end else begin
                    check("rx_data", bus.rx_data, exp_rx_q.pop_front());
                end
            end
            mon_prev = bus.rx_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r, r2, e, e2, d, mo;
        PRESET = 1'b1;
        bus.ss_n = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsbfe = 1'b0;
        bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ack = 1'b0;
        m_reset();
        repeat (3) @(negedge PClk);
        check("rst_miso", bus.miso, 0);
        check("rst_miso_oe", bus.miso_oe, 0);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_underrun", bus.underrun, 0);
        check("rst_busy", bus.busy, 0);
        PRESET = 1'b0;
        repeat (4) @(negedge PClk);

        // mode 0, MSB first
        set_mode(MODE0, 1'b0);
        tx_write(8'hA5);
        m_frame(8'h3C, 1, e);
        spi_xfer(8'h3C, W, 1, r);
        check("t1_master_rx", r, e);
        check_flags("t1");
        do_ack();

        // modes 1..3, LSB first
        for (int m = 1; m < 4; m++) begin
            set_mode(2'(m), 1'b1);
            tx_write(8'h81);
            m_frame(8'h7E, 1, e);
            spi_xfer(8'h7E, W, 1, r);
            check("t2_master_rx", r, e);
            check_flags("t2");
            do_ack();
        end

        // back-to-back frames, no ack in between
        set_mode(MODE0, 1'b0);
        tx_write(8'h5A);
        m_frame(8'h11, 1, e);
        m_write(8'hC3);
        m_frame(8'h22, 1, e2);
        fork
            begin
                spi_xfer(8'h11, W, 0, r);
                spi_xfer(8'h22, W, 1, r2);
            end
            tx_drive(8'hC3);
        join
        check("t3_master_rx1", r, e);
        check("t3_master_rx2", r2, e2);
        check("t3_rx_data", bus.rx_data, 8'h11);
        check_flags("t3");
        do_ack();
        check_flags("t3_ack");
        do_ack();
        check_flags("t3_ack_idle");

        // ss_n aborted after 3 sclk cycles
        d  = 8'($urandom);
        mo = 8'($urandom);
        tx_write(d);
        m_frame(mo, 0, e);
        spi_xfer(mo, 3, 1, r);
        check("t4_busy", bus.busy, 0);
        check("t4_miso_oe", bus.miso_oe, 0);
        check("t4_miso", bus.miso, 0);
        check_flags("t4");
        d  = 8'($urandom);
        mo = 8'($urandom);
        tx_write(d);
        m_frame(mo, 1, e);
        spi_xfer(mo, W, 1, r);
        check("t4_master_rx", r, e);
        check_flags("t4_full");
        do_ack();

        // no tx data: underrun and zeros on miso
        mo = 8'($urandom);
        m_frame(mo, 1, e);
        spi_xfer(mo, W, 1, r);
        check("t5_master_rx", r, e);
        check_flags("t5");
        tx_write(8'($urandom));
        check_flags("t5_wr");
        do_ack();

        // PRESET in the middle of a frame
        spi_xfer(8'($urandom), 3, 0, r);
        tx_drive(8'($urandom));
        #2 PRESET = 1'b1;
        #1;
        check("t6_miso", bus.miso, 0);
        check("t6_miso_oe", bus.miso_oe, 0);
        check("t6_tx_ready", bus.tx_ready, 1);
        check("t6_rx_data", bus.rx_data, 0);
        check("t6_rx_valid", bus.rx_valid, 0);
        check("t6_overrun", bus.overrun, 0);
        check("t6_underrun", bus.underrun, 0);
        check("t6_busy", bus.busy, 0);
        bus.ss_n = 1'b1;
        bus.sclk = bus.cpol;
        repeat (4) @(negedge PClk);
        PRESET = 1'b0;
        m_reset();
        repeat (4) @(negedge PClk);
        d  = 8'($urandom);
        mo = 8'($urandom);
        tx_write(d);
        m_frame(mo, 1, e);
        spi_xfer(mo, W, 1, r);
        check("t6_master_rx", r, e);
        check_flags("t6_after");
        do_ack();

        // randomized frames in random modes and bit orders
        for (int n = 0; n < 8; n++) begin
            set_mode(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if (!m_hold_full && $urandom_range(0, 3) != 0) tx_write(8'($urandom));
            mo = 8'($urandom);
            m_frame(mo, 1, e);
            spi_xfer(mo, W, 1, r);
            check("rnd_master_rx", r, e);
            check_flags("rnd");
            do_ack();
        end

        repeat (10) @(negedge PClk);
        check("rx_missing", exp_rx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
